// File: rtl/softcpu_pkg.sv
// Shared widths and read-FSM encoding for the soft CPU and its memory-side responder.
package softcpu_pkg;

    localparam int INSTR_W = 26;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } readState_t;

endpackage

// File: rtl/softcpu_sync_ram.sv
// Single-write-port RAM with a registered, enable-gated read; a same-edge write to the
// read address is returned on the read port (write-first). Only the read register resets.
module softcpu_sync_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          writeEnable,
    input  logic [AW-1:0] writeAddress,
    input  logic [DW-1:0] writeData,
    input  logic          readEnable,
    input  logic [AW-1:0] readAddress,
    output logic [DW-1:0] readData
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readData <= '0;
        end else if (readEnable) begin
            if (writeEnable && (writeAddress == readAddress)) begin
                readData <= writeData;
            end else begin
                readData <= mem[readAddress];
            end
        end
    end

endmodule

// File: rtl/soft_cpu_mem_responder.sv
// Memory-side responder for the soft CPU: 1-cycle instruction fetch, a load port for
// instruction memory, and latency-controlled data reads alongside non-stalling writes.
module soft_cpu_mem_responder
    import softcpu_pkg::*;
#(
    parameter int IMEM_ADDR_BITS = 8,
    parameter int DMEM_ADDR_BITS = 8,
    parameter int READ_LATENCY   = 2   // legal range 1..15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  instructionPointer,
    output logic [INSTR_W-1:0] instruction,
    output logic               instructionValid,
    input  logic [ADDR_W-1:0]  addressIn,
    input  logic               readValueIn,
    output logic [DATA_W-1:0]  valueIn,
    output logic               valueValid,
    output logic               busy,
    output logic               readOverrun,
    input  logic [ADDR_W-1:0]  addressOut,
    input  logic [DATA_W-1:0]  valueOut,
    input  logic               writeValueOut,
    input  logic               loadEnable,
    input  logic [ADDR_W-1:0]  loadAddress,
    input  logic [INSTR_W-1:0] loadInstruction,
    output readState_t         readState
);

    // Read protocol: readValueIn is a one-cycle request, accepted in IDLE or RESP.
    // valueValid is high for the single RESP cycle, READ_LATENCY cycles after the request;
    // a request seen while busy (WAIT) is dropped and flagged on readOverrun next cycle.
    readState_t                state, stateNext;
    logic [3:0]                counter, counterNext;
    logic [DMEM_ADDR_BITS-1:0] capAddr, capAddrNext;
    logic [DMEM_ADDR_BITS-1:0] dmemReadAddr;
    logic                      overrunNext;
    logic                      enterResp;
    logic                      unusedAddrBits;

    assign unusedAddrBits = ^{instructionPointer[ADDR_W-1:IMEM_ADDR_BITS],
                              loadAddress[ADDR_W-1:IMEM_ADDR_BITS],
                              addressIn[ADDR_W-1:DMEM_ADDR_BITS],
                              addressOut[ADDR_W-1:DMEM_ADDR_BITS]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= RD_IDLE;
            counter          <= '0;
            capAddr          <= '0;
            readOverrun      <= 1'b0;
            instructionValid <= 1'b0;
        end else begin
            state            <= stateNext;
            counter          <= counterNext;
            capAddr          <= capAddrNext;
            readOverrun      <= overrunNext;
            instructionValid <= !loadEnable;
        end
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        capAddrNext = capAddr;
        overrunNext = 1'b0;
        case (state)
            RD_IDLE, RD_RESP: begin
                stateNext = RD_IDLE;
                if (readValueIn) begin
                    capAddrNext = addressIn[DMEM_ADDR_BITS-1:0];
                    counterNext = 4'(READ_LATENCY - 1);
                    stateNext   = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                counterNext = counter - 4'd1;
                overrunNext = readValueIn;
                if (counter == 4'd1) begin
                    stateNext = RD_RESP;
                end
            end
            default: stateNext = RD_IDLE;
        endcase
    end

    // The edge entering RESP samples dmem; a same-edge write to that address is forwarded.
    assign enterResp    = (stateNext == RD_RESP);
    assign dmemReadAddr = (state == RD_WAIT) ? capAddr : addressIn[DMEM_ADDR_BITS-1:0];

    assign valueValid = (state == RD_RESP);
    assign busy       = (state == RD_WAIT);
    assign readState  = state;

    softcpu_sync_ram #(.AW(IMEM_ADDR_BITS), .DW(INSTR_W)) imem (
        .clock        (clock),
        .reset        (reset),
        .writeEnable  (loadEnable),
        .writeAddress (loadAddress[IMEM_ADDR_BITS-1:0]),
        .writeData    (loadInstruction),
        .readEnable   (!loadEnable),
        .readAddress  (instructionPointer[IMEM_ADDR_BITS-1:0]),
        .readData     (instruction)
    );

    softcpu_sync_ram #(.AW(DMEM_ADDR_BITS), .DW(DATA_W)) dmem (
        .clock        (clock),
        .reset        (reset),
        .writeEnable  (writeValueOut),
        .writeAddress (addressOut[DMEM_ADDR_BITS-1:0]),
        .writeData    (valueOut),
        .readEnable   (enterResp),
        .readAddress  (dmemReadAddr),
        .readData     (valueIn)
    );

endmodule
